wrr_client_ingress: RTL and testbench
=====================================

Name: wrr_client_ingress

Overview:
- Per-client ingress buffer that sits directly upstream of the weighted round-robin lock arbiter.
- Holds each client's beats in its own FIFO and derives the arbiter's request and lock vectors from FIFO occupancy and head-beat packet framing.
- Pops the granted client's head beat when the arbiter's one-hot grant returns, and presents it on a registered single-stream output with the client index attached.

Parameters:
- NUM_CLIENTS, 4, number of clients; must match the arbiter.
- DATA_WIDTH, 32, payload bits per beat.
- FIFO_DEPTH, 4, entries per client FIFO; power of two, at least 2.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- i_valid  input  NUM_CLIENTS  per-client beat valid.
- o_ready  output  NUM_CLIENTS  per-client FIFO can accept a beat.
- i_data  input  NUM_CLIENTS*DATA_WIDTH  packed payload; client k occupies [k*DATA_WIDTH +: DATA_WIDTH].
- i_last  input  NUM_CLIENTS  per-client last-beat-of-packet flag.
- o_req  output  NUM_CLIENTS  to arbiter i_req.
- o_lock  output  NUM_CLIENTS  to arbiter i_lock.
- i_gnt  input  NUM_CLIENTS  from arbiter o_gnt; one-hot or zero.
- o_valid  output  1  output beat valid (one-cycle pulse per beat; no backpressure).
- o_data  output  DATA_WIDTH  output payload.
- o_last  output  1  output last flag.
- o_client  output  $clog2(NUM_CLIENTS)  index of the source client.
- o_stale_gnt  output  1  grant received for an empty FIFO (one-cycle pulse).

Behaviour:
- Reset (rst=1 at a rising edge):
  - All FIFOs empty, all pointers and counts 0.
  - o_valid=0, o_data=0, o_last=0, o_client=0, o_stale_gnt=0.
  - o_req=0, o_lock=0, o_ready=all ones (combinational from the cleared counts).
  - Reset mid-packet discards all buffered beats; no partial output is emitted.
- FIFO k: circular buffer, {last, data} per entry. Count width is $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - o_ready[k] = (count_k < FIFO_DEPTH), from registered count only; no same-cycle pop bypass.
  - Push when i_valid[k] && o_ready[k]. i_valid while o_ready is low is ignored; the source must hold the beat.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
- Arbiter interface (combinational from registered FIFO state):
  - o_req[k] = (count_k != 0).
  - o_lock[k] = (count_k != 0) && !head_last_k, so a packet is held mid-flight while the next beat is buffered.
  - If the FIFO runs dry mid-packet, req and lock both drop and the arbiter may rotate away. This is accepted behaviour; sources must keep multi-beat packets contiguous to guarantee atomicity.
- Grant handling, cycle t:
  - Served client g = lowest set index of i_gnt. Extra bits are illegal and are ignored; only g is popped.
  - If count_g != 0: pop head of g. At t+1: o_valid=1, o_data/o_last = popped entry, o_client=g, o_stale_gnt=0.
  - If count_g == 0: no pop. At t+1: o_valid=0, o_stale_gnt=1. This is expected once per grant release because the arbiter's grant is registered one cycle behind i_req.
  - If i_gnt=0: at t+1 o_valid=0 and o_stale_gnt=0. o_data, o_last and o_client hold their last values.
- Latency, empty system: beat pushed at edge t → o_req=1 during t+1 → grant during t+2 → o_valid during t+3.
- Throughput: one beat per cycle for a continuously granted client whose FIFO stays non-empty.
- Reset-to-empty and full boundaries:
  - count reaching FIFO_DEPTH drops o_ready in the next cycle.
  - A pop from full raises o_ready in the next cycle.

Test Plan:
- Reset release, client 0 pushes one beat (data=0xA5, last=1) → o_req=0001 and o_lock=0000 one cycle later; with the arbiter attached, o_valid=1, o_data=0xA5, o_client=0 three cycles after the push; o_stale_gnt=1 in the following cycle.
- Client 2 pushes a 3-beat packet (0x10, 0x11, 0x12 with last on 0x12) while client 1 requests continuously → o_lock[2]=1 until the head is 0x12; output shows 0x10, 0x11, 0x12 from client 2 consecutively with no client-1 beat interleaved.
- Fill client 3 with FIFO_DEPTH=4 beats and no grant → o_ready[3]=0 after the 4th push; a 5th i_valid is not accepted; the first grant pops the entry and o_ready[3]=1 next cycle.
- Same-cycle push and pop on client 1 at count=2 → count stays 2 and output order matches push order across the pointer wrap (push 8 beats total, check 8 in order).
- Drive i_gnt=0100 with client 2 empty → no pop, o_valid=0, o_stale_gnt=1 next cycle; drive i_gnt=0110 with both clients non-empty → only client 1 popped, o_client=1.
- Assert rst with 2 beats buffered in each FIFO → next cycle o_req=0, o_ready=1111, o_valid=0, and no buffered beat ever appears on the output.

Source files
------------

// File: rtl/wrr_client_ingress_if.sv
// Purpose: per-client ingress beat bus (valid/ready/data/last) feeding the
//          weighted round-robin client ingress buffer.
// Signals:
//   valid[k] - client k presents a beat
//   ready[k] - client k FIFO can accept a beat
//   data     - packed payload, client k at [k*DATA_WIDTH +: DATA_WIDTH]
//   last[k]  - beat is the last of its packet
// Modports: master = beat source, slave = ingress buffer.
interface wrr_client_ingress_if #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned DATA_WIDTH  = 32
);
  logic [NUM_CLIENTS-1:0]            valid;
  logic [NUM_CLIENTS-1:0]            ready;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0] data;
  logic [NUM_CLIENTS-1:0]            last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/wrr_client_ingress.sv
// Purpose: per-client ingress FIFOs upstream of the WRR lock arbiter. Derives
//          request/lock vectors from FIFO occupancy and head-beat framing, pops
//          the granted client's head beat and emits it on a registered stream.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   i_in          - ingress beat bus (slave side), ready driven from counts
//   o_req, o_lock - to arbiter request / lock inputs
//   i_gnt         - arbiter grant, one-hot or zero (lowest set bit served)
//   o_valid, o_data, o_last, o_client - registered output beat
//   o_stale_gnt   - pulse: grant arrived for an empty FIFO
module wrr_client_ingress #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH  = 4,
  localparam int unsigned CLIENT_W   = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  wrr_client_ingress_if.slave    i_in,
  output logic [NUM_CLIENTS-1:0] o_req,
  output logic [NUM_CLIENTS-1:0] o_lock,
  input  logic [NUM_CLIENTS-1:0] i_gnt,
  output logic                   o_valid,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_last,
  output logic [CLIENT_W-1:0]    o_client,
  output logic                   o_stale_gnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = DATA_WIDTH + 1;

  // Entry layout: {last, data}
  logic [ENT_W-1:0] r_mem  [NUM_CLIENTS][FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr [NUM_CLIENTS];
  logic [PTR_W-1:0] r_rptr [NUM_CLIENTS];
  logic [CNT_W-1:0] r_cnt  [NUM_CLIENTS];

  logic [NUM_CLIENTS-1:0] w_ready;
  logic [NUM_CLIENTS-1:0] w_push;
  logic [NUM_CLIENTS-1:0] w_pop;
  logic [ENT_W-1:0]       w_head [NUM_CLIENTS];
  logic                   w_gnt_any;
  logic [CLIENT_W-1:0]    w_gnt_idx;
  logic                   w_gnt_hit;
  logic [ENT_W-1:0]       w_gnt_head;

  assign i_in.ready = w_ready;

  // Per-client status from registered counts only (no pop bypass into ready)
  always_comb begin
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      w_ready[k] = (r_cnt[k] < CNT_W'(FIFO_DEPTH));
      w_push[k]  = i_in.valid[k] && w_ready[k];
      w_head[k]  = r_mem[k][r_rptr[k]];
      o_req[k]   = (r_cnt[k] != '0);
      o_lock[k]  = (r_cnt[k] != '0) && !w_head[k][ENT_W-1];
    end
  end

  // Grant decode: lowest set bit wins, extra bits are ignored
  always_comb begin
    w_gnt_any = |i_gnt;
    w_gnt_idx = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      if (i_gnt[k]) w_gnt_idx = CLIENT_W'(k);
    end
    w_gnt_head = w_head[w_gnt_idx];
    w_gnt_hit  = w_gnt_any && o_req[w_gnt_idx];
    w_pop      = '0;
    if (w_gnt_hit) w_pop[w_gnt_idx] = 1'b1;
  end

  // FIFO storage, no reset needed: occupancy gates every read
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (w_push[k]) begin
        r_mem[k][r_wptr[k]] <= {i_in.last[k], i_in.data[k*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  // Pointers and counts; pointers wrap naturally since depth is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CLIENTS; k++) begin
        r_wptr[k] <= '0;
        r_rptr[k] <= '0;
        r_cnt[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CLIENTS; k++) begin
        if (w_push[k]) r_wptr[k] <= r_wptr[k] + PTR_W'(1);
        if (w_pop[k])  r_rptr[k] <= r_rptr[k] + PTR_W'(1);
        case ({w_push[k], w_pop[k]})
          2'b10:   r_cnt[k] <= r_cnt[k] + CNT_W'(1);
          2'b01:   r_cnt[k] <= r_cnt[k] - CNT_W'(1);
          default: r_cnt[k] <= r_cnt[k];
        endcase
      end
    end
  end

  // Registered output stream; payload fields hold between beats
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_last      <= 1'b0;
      o_client    <= '0;
      o_stale_gnt <= 1'b0;
    end else begin
      o_valid     <= w_gnt_hit;
      o_stale_gnt <= w_gnt_any && !w_gnt_hit;
      if (w_gnt_hit) begin
        o_data   <= w_gnt_head[DATA_WIDTH-1:0];
        o_last   <= w_gnt_head[ENT_W-1];
        o_client <= w_gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_wrr_client_ingress.sv
// Purpose: self-checking bench for wrr_client_ingress. A queue-based model
//          tracks every client's buffered beats and the expected output; a
//          negedge process compares all outputs each cycle, and directed
//          scenarios add literal expectations before a randomized phase.
module tb_wrr_client_ingress;
  localparam int NC = 4;
  localparam int DW = 32;
  localparam int FD = 4;

  typedef logic [DW:0] ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [NC-1:0] valid, last, gnt;
  logic [NC*DW-1:0] data;

  logic [NC-1:0] o_req, o_lock;
  logic          o_valid, o_last, o_stale_gnt;
  logic [DW-1:0] o_data;
  logic [1:0]    o_client;

  wrr_client_ingress_if #(.NUM_CLIENTS(NC), .DATA_WIDTH(DW)) bus ();
  assign bus.valid = valid;
  assign bus.data  = data;
  assign bus.last  = last;

  wrr_client_ingress #(.NUM_CLIENTS(NC), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .i_in(bus),
    .o_req(o_req), .o_lock(o_lock), .i_gnt(gnt),
    .o_valid(o_valid), .o_data(o_data), .o_last(o_last),
    .o_client(o_client), .o_stale_gnt(o_stale_gnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: one queue of {last,data} per client
  ent_t       q [NC][$];
  logic       m_valid, m_last, m_stale;
  logic [DW-1:0] m_data;
  logic [1:0] m_client;
  int         m_sz [NC];
  int         m_g;
  ent_t       m_e;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NC; k++) q[k].delete();
      m_valid = 1'b0; m_last = 1'b0; m_stale = 1'b0;
      m_data = '0; m_client = '0;
    end else begin
      for (int k = 0; k < NC; k++) m_sz[k] = q[k].size();
      m_g = -1;
      for (int k = NC - 1; k >= 0; k--) if (gnt[k]) m_g = k;
      m_valid = 1'b0;
      m_stale = 1'b0;
      if (m_g >= 0) begin
        if (m_sz[m_g] > 0) begin
          m_e      = q[m_g].pop_front();
          m_valid  = 1'b1;
          m_data   = m_e[DW-1:0];
          m_last   = m_e[DW];
          m_client = 2'(m_g);
        end else begin
          m_stale = 1'b1;
        end
      end
      for (int k = 0; k < NC; k++)
        if (valid[k] && m_sz[k] < FD) q[k].push_back({last[k], data[k*DW +: DW]});
    end
  end

  // Per-cycle comparison of every output against the model
  logic [NC-1:0] e_ready, e_req, e_lock;
  always @(negedge clk) begin
    for (int k = 0; k < NC; k++) begin
      e_ready[k] = (q[k].size() < FD);
      e_req[k]   = (q[k].size() != 0);
      e_lock[k]  = (q[k].size() != 0) ? !q[k][0][DW] : 1'b0;
    end
    chk("ready", bus.ready, e_ready);
    chk("req", o_req, e_req);
    chk("lock", o_lock, e_lock);
    chk("valid", o_valid, m_valid);
    chk("stale", o_stale_gnt, m_stale);
    chk("data", o_data, m_data);
    chk("last", o_last, m_last);
    chk("client", o_client, m_client);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid = '0; last = '0; gnt = '0; data = '0;
    tick(); tick();
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", bus.ready, 4'b1111);
    chk("rst_req", o_req, 0);
    chk("rst_lock", o_lock, 0);
    chk("rst_stale", o_stale_gnt, 0);
    chk("rst_data", o_data, 0);
    rst = 1'b0;

    // Single beat on client 0 with arbiter-like grant timing
    valid = 4'b0001; data[31:0] = 32'hA5; last = 4'b0001;
    tick();
    valid = '0; last = '0;
    chk("t1_req", o_req, 4'b0001);
    chk("t1_lock", o_lock, 4'b0000);
    tick();
    gnt = 4'b0001;
    tick();
    chk("t1_valid", o_valid, 1);
    chk("t1_data", o_data, 32'hA5);
    chk("t1_client", o_client, 0);
    chk("t1_last", o_last, 1);
    tick();
    chk("t1_stale", o_stale_gnt, 1);
    chk("t1_novalid", o_valid, 0);
    gnt = '0;
    tick();
    chk("t1_stale_clr", o_stale_gnt, 0);

    // Client 2 three-beat packet, client 1 also requesting
    for (int i = 0; i < 3; i++) begin
      valid = (i == 0) ? 4'b0110 : 4'b0100;
      data[2*DW +: DW] = 32'h10 + 32'(i);
      data[1*DW +: DW] = 32'h77;
      last = (i == 2) ? 4'b0110 : 4'b0010;
      tick();
    end
    valid = '0; last = '0;
    chk("t2_lock0", o_lock, 4'b0100);
    gnt = 4'b0100;
    tick();
    chk("t2_d0", o_data, 32'h10); chk("t2_c0", o_client, 2);
    chk("t2_lock1", o_lock, 4'b0100);
    tick();
    chk("t2_d1", o_data, 32'h11);
    chk("t2_lock2", o_lock, 4'b0000);
    tick();
    chk("t2_d2", o_data, 32'h12); chk("t2_l2", o_last, 1); chk("t2_c2", o_client, 2);
    gnt = 4'b0010;
    tick();
    chk("t2_c1", o_client, 1); chk("t2_d1b", o_data, 32'h77);
    tick();
    gnt = '0;
    tick();

    // Fill client 3, fifth beat must be refused
    for (int i = 0; i < 4; i++) begin
      valid = 4'b1000; data[3*DW +: DW] = 32'h30 + 32'(i);
      tick();
    end
    chk("t3_full", bus.ready, 4'b0111);
    data[3*DW +: DW] = 32'h34;
    tick();
    chk("t3_full2", bus.ready, 4'b0111);
    valid = '0;
    gnt = 4'b1000;
    tick();
    chk("t3_d0", o_data, 32'h30);
    chk("t3_ready", bus.ready, 4'b1111);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t3_dn", o_data, 32'h30 + 32'(i));
    end
    tick();
    chk("t3_stale", o_stale_gnt, 1);
    chk("t3_hold", o_data, 32'h33);
    gnt = '0;
    tick();

    // Client 1 simultaneous push and pop across pointer wrap
    valid = 4'b0010; last = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      data[DW +: DW] = 32'h40 + 32'(i);
      tick();
    end
    gnt = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      data[DW +: DW] = 32'h42 + 32'(i);
      tick();
      chk("t4_order", o_data, 32'h40 + 32'(i));
      chk("t4_ready", bus.ready, 4'b1111);
    end
    valid = '0; last = '0;
    for (int i = 6; i < 8; i++) begin
      tick();
      chk("t4_drain", o_data, 32'h40 + 32'(i));
    end
    tick();
    gnt = '0;
    tick();

    // Stale grant and multi-hot grant
    gnt = 4'b0100;
    tick();
    chk("t5_valid", o_valid, 0);
    chk("t5_stale", o_stale_gnt, 1);
    gnt = '0;
    valid = 4'b0110; last = 4'b0110;
    data[1*DW +: DW] = 32'h51; data[2*DW +: DW] = 32'h52;
    tick();
    valid = '0; last = '0;
    gnt = 4'b0110;
    tick();
    chk("t5_mh_valid", o_valid, 1);
    chk("t5_mh_client", o_client, 1);
    chk("t5_mh_data", o_data, 32'h51);
    gnt = 4'b0100;
    tick();
    chk("t5_c2", o_client, 2);
    chk("t5_d2", o_data, 32'h52);
    gnt = '0;
    tick();

    // Reset with beats buffered everywhere
    valid = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < NC; k++) data[k*DW +: DW] = $urandom;
      last = 4'($urandom);
      tick();
    end
    valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_req", o_req, 0);
    chk("t6_ready", bus.ready, 4'b1111);
    chk("t6_valid", o_valid, 0);
    gnt = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_noout", o_valid, 0);
    end
    gnt = '0;
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      valid = 4'($urandom);
      last  = 4'($urandom);
      for (int k = 0; k < NC; k++) data[k*DW +: DW] = $urandom;
      gnt = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; valid = '0; gnt = '0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
